instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 141 ++++++++++++++
 tb/tb_instr_encoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: accepts encode requests, builds the 32-bit word and
// queues it with its word address in a small FIFO for a downstream consumer.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter logic [31:0] LAST_ADDR = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_shamt,
    input  logic [25:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic [4:0]  count,
    output logic        err_illegal
);

    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [4:0]       count_q, count_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      head_instr_q, head_instr_d;
    logic [31:0]      head_addr_q, head_addr_d;
    logic             err_q, err_d;
    logic [63:0]      mem_q [DEPTH];

    logic        accept, legal, push, pop;
    logic [31:0] enc_word;

    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  sh,
        input logic [25:0] imm
    );
        logic [31:0] w;
        case (op)
            4'd0:    w = {6'h00, rs, rt, rd, 5'd0, 6'h20};
            4'd1:    w = {6'h00, rs, rt, rd, 5'd0, 6'h22};
            4'd2:    w = {6'h0D, rs, rt, imm[15:0]};
            4'd3:    w = {6'h23, rs, rt, imm[15:0]};
            4'd4:    w = {6'h2B, rs, rt, imm[15:0]};
            4'd5:    w = {6'h04, rs, rt, imm[15:0]};
            4'd6:    w = {6'h00, 5'd0, rt, rd, sh, 6'h00};
            4'd7:    w = {6'h0F, 5'd0, rt, imm[15:0]};
            4'd8:    w = {6'h02, imm};
            4'd9:    w = {6'h03, imm};
            4'd10:   w = {6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h08};
            4'd11:   w = {6'h00, rs, 5'd0, rd, 5'd0, 6'h09};
            4'd12:   w = {6'h20, rs, rt, imm[15:0]};
            4'd13:   w = {6'h28, rs, rt, imm[15:0]};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Ready is gated by the reset pin so it reads 0 while reset is held.
    assign req_ready   = reset && (count_q < DEPTH_C);
    assign out_valid   = (count_q != 5'd0);
    assign accept      = req_valid && req_ready;
    assign legal       = (req_op < 4'd14);
    assign push        = accept && legal;
    assign pop         = out_valid && out_ready;
    assign enc_word    = encode(req_op, req_rs, req_rt, req_rd, req_shamt, req_imm);

    assign out_instr   = head_instr_q;
    assign out_addr    = head_addr_q;
    assign count       = count_q;
    assign err_illegal = err_q;

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        addr_d       = addr_q;
        err_d        = err_q | (accept && !legal);
        head_instr_d = head_instr_q;
        head_addr_d  = head_addr_q;

        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            addr_d   = (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + 32'd4;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        // The head register mirrors the entry at the next read pointer; when
        // everything older is leaving, that entry is the word being written now.
        if (count_d != 5'd0) begin
            if (push && (count_q == {4'd0, pop})) begin
                head_instr_d = enc_word;
                head_addr_d  = addr_q;
            end else begin
                head_instr_d = mem_q[rd_ptr_d][31:0];
                head_addr_d  = mem_q[rd_ptr_d][63:32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= 5'd0;
            addr_q       <= BASE_ADDR;
            err_q        <= 1'b0;
            head_instr_q <= 32'h0;
            head_addr_q  <= 32'h0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            err_q        <= err_d;
            head_instr_q <= head_instr_d;
            head_addr_q  <= head_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {addr_q, enc_word};
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_instr_encoder;

    localparam int          DEPTH     = 4;
    localparam logic [31:0] BASE_ADDR = 32'h0000_3000;
    localparam logic [31:0] LAST_ADDR = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'd0;
    logic [4:0]  req_rs = 5'd0, req_rt = 5'd0, req_rd = 5'd0, req_shamt = 5'd0;
    logic [25:0] req_imm = 26'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr, out_addr;
    logic [4:0]  count;
    logic        err_illegal;

    int checks = 0;
    int errors = 0;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .LAST_ADDR(LAST_ADDR)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
        .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .count(count), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // Reference encoder: look up opcode/funct and which fields the op keeps.
    function automatic logic [31:0] m_enc(input logic [3:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [25:0] imm);
        logic [31:0] opc, fn;
        bit k_rs, k_rt, k_rd, k_sh, itype, jtype;
        logic [31:0] r;
        opc = 0; fn = 0; k_rs = 0; k_rt = 0; k_rd = 0; k_sh = 0; itype = 0; jtype = 0;
        case (op)
            4'd0:  begin fn = 32; k_rs = 1; k_rt = 1; k_rd = 1; end
            4'd1:  begin fn = 34; k_rs = 1; k_rt = 1; k_rd = 1; end
            4'd2:  begin opc = 13; k_rs = 1; k_rt = 1; itype = 1; end
            4'd3:  begin opc = 35; k_rs = 1; k_rt = 1; itype = 1; end
            4'd4:  begin opc = 43; k_rs = 1; k_rt = 1; itype = 1; end
            4'd5:  begin opc = 4;  k_rs = 1; k_rt = 1; itype = 1; end
            4'd6:  begin fn = 0;  k_rt = 1; k_rd = 1; k_sh = 1; end
            4'd7:  begin opc = 15; k_rt = 1; itype = 1; end
            4'd8:  begin opc = 2;  jtype = 1; end
            4'd9:  begin opc = 3;  jtype = 1; end
            4'd10: begin fn = 8;  k_rs = 1; end
            4'd11: begin fn = 9;  k_rs = 1; k_rd = 1; end
            4'd12: begin opc = 32; k_rs = 1; k_rt = 1; itype = 1; end
            4'd13: begin opc = 40; k_rs = 1; k_rt = 1; itype = 1; end
            default: ;
        endcase
        r = (opc << 26) + fn;
        if (k_rs) r = r + (32'(rs) << 21);
        if (k_rt) r = r + (32'(rt) << 16);
        if (k_rd) r = r + (32'(rd) << 11);
        if (k_sh) r = r + (32'(sh) << 6);
        if (itype) r = r + (32'(imm) & 32'h0000_FFFF);
        if (jtype) r = r + 32'(imm);
        return r;
    endfunction

    logic [63:0] mq[$];
    logic [63:0] m_last;
    logic [31:0] m_addr;
    bit          m_err;
    logic [63:0] plog[$];

    // Model state: the queue is the FIFO contents, m_last the last word popped.
    initial begin
        bit acc, pp;
        m_last = 64'd0; m_addr = BASE_ADDR; m_err = 0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                mq.delete(); m_addr = BASE_ADDR; m_err = 0; m_last = 64'd0;
            end else begin
                acc = req_valid && (mq.size() < DEPTH);
                pp  = (mq.size() > 0) && out_ready;
                if (pp) m_last = mq.pop_front();
                if (acc) begin
                    if (req_op >= 4'd14) m_err = 1;
                    else begin
                        mq.push_back({m_addr, m_enc(req_op, req_rs, req_rt, req_rd, req_shamt, req_imm)});
                        m_addr = (m_addr == LAST_ADDR) ? BASE_ADDR : m_addr + 32'd4;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, on the falling edge.
    initial begin
        logic [63:0] head;
        forever begin
            @(negedge clk);
            head = (mq.size() > 0) ? mq[0] : m_last;
            chk("count", 32'(count), 32'(mq.size()));
            chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("req_ready", 32'(req_ready), 32'(reset && (mq.size() < DEPTH)));
            chk("err_illegal", 32'(err_illegal), 32'(m_err));
            chk("out_instr", out_instr, head[31:0]);
            chk("out_addr", out_addr, head[63:32]);
            if (reset && out_valid && out_ready) plog.push_back({out_addr, out_instr});
        end
    end

    task automatic push(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm);
        bit acc;
        acc = 0;
        req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sh; req_imm = imm;
        req_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        chk("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        plog.delete();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_addr", out_addr, 32'h0);
        #2 reset = 1'b1;
        @(posedge clk); #1;

        // add rs=1 rt=2 rd=3
        out_ready = 1'b1;
        push(4'd0, 5'd1, 5'd2, 5'd3, 5'd7, 26'h155);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_instr", out_instr, 32'h0022_1820);
        chk("add_addr", out_addr, 32'h0000_3000);

        // ori then jal
        do_reset();
        out_ready = 1'b1;
        push(4'd2, 5'd0, 5'd1, 5'd0, 5'd0, 26'h0001234);
        chk("ori_instr", out_instr, 32'h3401_1234);
        chk("ori_addr", out_addr, 32'h0000_3000);
        push(4'd9, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0000C01);
        chk("jal_instr", out_instr, 32'h0C00_0C01);
        chk("jal_addr", out_addr, 32'h0000_3004);

        // illegal op followed by sub
        do_reset();
        out_ready = 1'b0;
        push(4'd15, 5'd3, 5'd3, 5'd3, 5'd3, 26'h3);
        push(4'd1, 5'd4, 5'd5, 5'd6, 5'd9, 26'h0);
        chk("ill_err", 32'(err_illegal), 32'd1);
        chk("ill_count", 32'(count), 32'd1);
        chk("sub_instr", out_instr, 32'h0085_3022);
        chk("sub_addr", out_addr, 32'h0000_3000);
        repeat (3) @(posedge clk);
        #1 chk("ill_sticky", 32'(err_illegal), 32'd1);

        // fill to full, stall the fifth request, check order
        do_reset();
        out_ready = 1'b0;
        push(4'd3, 5'd2, 5'd3, 5'd0, 5'd0, 26'h0010);
        push(4'd4, 5'd2, 5'd4, 5'd0, 5'd0, 26'h0020);
        push(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 26'hFFFF);
        push(4'd6, 5'd7, 5'd8, 5'd9, 5'd4, 26'h0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(req_ready), 32'd0);
        req_op = 4'd7; req_rs = 5'd5; req_rt = 5'd6; req_imm = 26'hABCD; req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("stall_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("pop_no_accept", 32'(count), 32'd3);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("fifth_accept", 32'(count), 32'd4);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("order_len", 32'(plog.size()), 32'd5);
        if (plog.size() >= 5) begin
            chk("order0", plog[0][31:0], 32'h8C43_0010);
            chk("order1", plog[1][31:0], 32'hAC44_0020);
            chk("order2", plog[2][31:0], 32'h1022_FFFF);
            chk("order3", plog[3][31:0], 32'h0008_4900);
            chk("order4", plog[4][31:0], 32'h3C06_ABCD);
            chk("order4_addr", plog[4][63:32], 32'h0000_3010);
        end

        // every opcode with all fields non-zero, consumer toggling
        do_reset();
        for (int op = 0; op < 16; op++) begin
            out_ready = op[0];
            push(4'(op), 5'h11, 5'h12, 5'h13, 5'h1F, 26'h25AC3F1);
        end
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // reset while three words are queued
        do_reset();
        out_ready = 1'b0;
        push(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0);
        push(4'd0, 5'd1, 5'd1, 5'd1, 5'd0, 26'h0);
        push(4'd8, 5'd0, 5'd0, 5'd0, 5'd0, 26'h1234567);
        push(4'd10, 5'd31, 5'd1, 5'd1, 5'd1, 26'h0);
        chk("pre_count", 32'(count), 32'd3);
        chk("pre_err", 32'(err_illegal), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_err", 32'(err_illegal), 32'd0);
        chk("mid_instr", out_instr, 32'h0);
        plog.delete();
        @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("post_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(4'd11, 5'd2, 5'd9, 5'd3, 5'd8, 26'h0);
        chk("post_instr", out_instr, 32'h0040_1809);
        chk("post_addr", out_addr, 32'h0000_3000);

        // address counter wrap
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4097; i++) push(4'd0, 5'(i), 5'(i >> 5), 5'd1, 5'd0, 26'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("wrap_len", 32'(plog.size()), 32'd4097);
        if (plog.size() >= 4097) begin
            chk("wrap_last_addr", plog[4095][63:32], 32'h0000_6FFC);
            chk("wrap_next_addr", plog[4096][63:32], 32'h0000_3000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
